// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared types and line levels for the serial tx/rx link.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timer
// Description : Counts clock cycles within one bit period; flags the last one.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int                c_cnt_w = min1_clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_end = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx
// Description : LSB-first serializer with start/stop framing and valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int                 c_bit_w    = min1_clog2(DATA_WIDTH);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic                  w_bit_end;
    logic                  w_idle;

    assign w_idle       = (r_state == IDLE);
    assign tx_ready     = w_idle;
    assign w_shift_next = r_shift >> 1;

    // Held clear while idle so the first START cycle always begins at count 0.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_idle),
        .bit_end(w_bit_end)
    );

    // tx_serial is loaded with the level of the state being entered, so the
    // line changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            tx_serial <= LINE_IDLE;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_shift   <= tx_data;
                        r_bit_cnt <= '0;
                        r_state   <= START;
                        tx_serial <= START_BIT;
                        tx_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        tx_serial <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state   <= STOP;
                            tx_serial <= STOP_BIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            tx_serial <= w_shift_next[0];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_state   <= IDLE;
                        tx_serial <= LINE_IDLE;
                        tx_busy   <= 1'b0;
                        tx_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    tx_serial <= LINE_IDLE;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx
// Description : Self-checking bench for serial_tx at 4 and 1 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       v4, v1;
    logic [7:0] d4, d1;
    logic       ready4, line4, busy4, done4;
    logic       ready1, line1, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .tx_valid(v4), .tx_data(d4),
        .tx_ready(ready4), .tx_serial(line4), .tx_busy(busy4), .tx_done(done4)
    );

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .tx_valid(v1), .tx_data(d1),
        .tx_ready(ready1), .tx_serial(line1), .tx_busy(busy1), .tx_done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            v1 = v;
            d1 = d;
        end else begin
            v4 = v;
            d4 = d;
        end
    endtask

    // Expected line level k cycles into a frame: start, 8 data bits LSB-first, stop.
    function automatic logic exp_bit(input logic [7:0] w, input int k, input int cpb);
        int b;
        b = k / cpb;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return w[b-1];
    endfunction

    task automatic check_out(input bit sel, input string tag, input logic e_line,
                             input logic e_ready, input logic e_busy, input logic e_done);
        chk({tag, " line"},  {31'd0, sel ? line1  : line4},  {31'd0, e_line});
        chk({tag, " ready"}, {31'd0, sel ? ready1 : ready4}, {31'd0, e_ready});
        chk({tag, " busy"},  {31'd0, sel ? busy1  : busy4},  {31'd0, e_busy});
        chk({tag, " done"},  {31'd0, sel ? done1  : done4},  {31'd0, e_done});
    endtask

    task automatic check_idle(input bit sel, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_out(sel, $sformatf("%s idle%0d", tag, i), 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
    endtask

    // Entered on the first START cycle of a frame carrying w.
    task automatic run_frame(input logic [7:0] w, input bit sel, input bit noise,
                             input bit chain, input logic [7:0] nd);
        int cpb;
        int len;
        cpb = sel ? 1 : 4;
        len = 10 * cpb;
        drive(sel, chain, 8'($urandom));
        for (int k = 0; k < len; k++) begin
            if (noise && k == 5) drive(sel, 1'b1, 8'hFF);
            if (noise && k == 6) drive(sel, 1'b0, 8'hFF);
            check_out(sel, $sformatf("u%0d f%02h k%0d", sel, w, k),
                      exp_bit(w, k, cpb), 1'b0, 1'b1, 1'b0);
            step();
        end
        check_out(sel, $sformatf("u%0d f%02h end", sel, w), 1'b1, 1'b1, 1'b0, 1'b1);
        if (chain) begin
            drive(sel, 1'b1, nd);
            step();
        end else begin
            drive(sel, 1'b0, 8'($urandom));
            step();
            check_idle(sel, 1, $sformatf("u%0d f%02h post", sel, w));
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] w2;
        reset = 1'b1;
        v4 = 1'b0; v1 = 1'b0; d4 = 8'h00; d1 = 8'h00;
        repeat (3) step();
        check_out(0, "rst4", 1'b1, 1'b1, 1'b0, 1'b0);
        check_out(1, "rst1", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_out(0, $sformatf("idle4 %0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            check_out(1, $sformatf("idle1 %0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end

        drive(0, 1'b1, 8'hA5); step();
        run_frame(8'hA5, 0, 0, 0, 8'h00);

        drive(0, 1'b1, 8'h3C); step();
        run_frame(8'h3C, 0, 1, 0, 8'h00);
        check_idle(0, 5, "after3C");

        drive(0, 1'b1, 8'h01); step();
        run_frame(8'h01, 0, 0, 1, 8'h80);
        run_frame(8'h80, 0, 0, 0, 8'h00);

        // Reset during the third data bit (cycles 12..15) of 0x55.
        drive(0, 1'b1, 8'h55); step();
        drive(0, 1'b0, 8'($urandom));
        for (int k = 0; k < 13; k++) begin
            check_out(0, $sformatf("r55 k%0d", k), exp_bit(8'h55, k, 4), 1'b0, 1'b1, 1'b0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out(0, "r55 abort", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check_idle(0, 4, "r55");
        drive(0, 1'b1, 8'h0F); step();
        run_frame(8'h0F, 0, 0, 0, 8'h00);

        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            drive(0, 1'b1, w); step();
            run_frame(w, 0, 1'($urandom_range(0, 1)), 0, 8'h00);
        end

        drive(1, 1'b1, 8'hFF); step();
        run_frame(8'hFF, 1, 0, 0, 8'h00);

        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            drive(1, 1'b1, w); step();
            run_frame(w, 1, 1'($urandom_range(0, 1)), 0, 8'h00);
        end

        w  = 8'($urandom);
        w2 = 8'($urandom);
        drive(1, 1'b1, w); step();
        run_frame(w, 1, 0, 1, w2);
        run_frame(w2, 1, 0, 0, 8'h00);
        check_idle(1, 3, "end1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
